// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment patterns ({g,f,e,d,c,b,a})
// and the default number of scanned digits.
package seg7_pkg;

  localparam int DIGITS_DEFAULT = 4;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0    = 7'h40;
  localparam seg7_t SEG_1    = 7'h79;
  localparam seg7_t SEG_2    = 7'h24;
  localparam seg7_t SEG_3    = 7'h30;
  localparam seg7_t SEG_4    = 7'h19;
  localparam seg7_t SEG_5    = 7'h12;
  localparam seg7_t SEG_6    = 7'h02;
  localparam seg7_t SEG_7    = 7'h78;
  localparam seg7_t SEG_8    = 7'h00;
  localparam seg7_t SEG_9    = 7'h10;
  localparam seg7_t SEG_DASH = 7'h3F;
  localparam seg7_t SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Time-multiplexed common-anode display driver for a packed BCD count, with
// leading-zero blanking and a sticky overflow indicator on the last digit's dp.
module bcd_display_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEFAULT,
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16,
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  ovr,
  input  logic                  clr_ovr,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic [IDX_W-1:0]      digit_idx
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    r_div;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_snap;
  logic                r_ovr_flag;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  logic                w_tick;
  logic [3:0]          w_digit [DIGITS];
  logic [DIGITS:1]     w_zero_up;
  logic [DIGITS-1:0]   w_blank;
  logic [DIGITS-1:0]   w_an_next;
  logic [3:0]          w_cur_digit;
  logic [6:0]          w_cur_seg;
  logic                w_cur_blank;

  assign w_tick = enable && (r_div == DIV_LAST);

  // w_zero_up[i]: digit i and every digit above it are zero (invalid codes
  // compare as nonzero, so a dash is never blanked).
  assign w_zero_up[DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_digit[gi]   = r_snap[4*gi +: 4];
      assign w_an_next[gi] = (r_idx != IDX_W'(gi));
    end

    for (gi = 1; gi < DIGITS; gi++) begin : g_zero
      assign w_zero_up[gi] = (w_digit[gi] == 4'd0) && w_zero_up[gi+1];
      assign w_blank[gi]   = blank_lz && w_zero_up[gi];
    end
  endgenerate

  assign w_blank[0]  = 1'b0;
  assign w_cur_digit = w_digit[r_idx];
  assign w_cur_blank = w_blank[r_idx];

  bcd_to_seg7 u_dec (
    .i_bcd (w_cur_digit),
    .o_seg (w_cur_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div      <= '0;
      r_idx      <= '0;
      r_snap     <= '0;
      r_ovr_flag <= 1'b0;
      r_seg      <= SEG_OFF;
      r_dp       <= 1'b1;
      r_an       <= '1;
    end else begin
      if (load) begin
        r_snap <= bcd_in;
      end

      // Set has priority so an overflow coinciding with a clear is not lost.
      if (ovr) begin
        r_ovr_flag <= 1'b1;
      end else if (clr_ovr) begin
        r_ovr_flag <= 1'b0;
      end

      if (enable) begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (w_tick) begin
          r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end
        r_seg <= w_cur_blank ? SEG_OFF : w_cur_seg;
        r_dp  <= ~(r_ovr_flag && (r_idx == IDX_LAST));
        r_an  <= w_an_next;
      end
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign an        = r_an;
  assign digit_idx = r_idx;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: stimulus pushes cycle-tagged expected display states,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_bcd_display_scan;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S7 = 7'h78, S9 = 7'h10;
  localparam logic [6:0] SDASH = 7'h3F, SOFF = 7'h7F;

  logic        clk = 1'b0;
  logic        reset, enable, load, ovr, clr_ovr, blank_lz;
  logic [15:0] bcd_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  bcd_display_scan #(.DIGITS(4), .REFRESH_DIV(4), .DIV_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .bcd_in    (bcd_in),
    .ovr       (ovr),
    .clr_ovr   (clr_ovr),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   ph  = 0;     // enabled edges since the last reset edge
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (an !== e.an || seg !== e.seg || dp !== e.dp || digit_idx !== e.idx) begin
        errors++;
        $display("FAIL %s: got an=%h seg=%h dp=%b idx=%0d, want an=%h seg=%h dp=%b idx=%0d",
                 e.name, an, seg, dp, digit_idx, e.an, e.seg, e.dp, e.idx);
      end else begin
        $display("ok   %s: an=%h seg=%h dp=%b idx=%0d", e.name, an, seg, dp, digit_idx);
      end
    end
  end

  task automatic tick1();
    @(posedge clk);
    if (reset) ph = 0;
    else if (enable) ph++;
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d,
                      input logic [1:0] i, input string name);
    exp_t e;
    e.cyc = cyc; e.an = a; e.seg = s; e.dp = d; e.idx = i; e.name = name;
    q.push_back(e);
  endtask

  // Advance to the first cycle on which digit d is displayed, then expect it.
  task automatic goto_digit(input int d, input logic [6:0] s, input logic dpv,
                            input string name);
    bit found = 0;
    for (int k = 0; k < 64; k++) begin
      tick1();
      if (ph >= 1 && ((ph - 1) % 4 == 0) && (((ph - 1) / 4) % 4 == d)) begin
        found = 1;
        break;
      end
    end
    if (found) begin
      push(~(4'b0001 << d), s, dpv, 2'(d), name);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: digit %0d never reached", name, d);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bcd_in = v;
    load = 1'b1;
    tick1();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; load = 1'b0; ovr = 1'b0; clr_ovr = 1'b0;
    blank_lz = 1'b0; bcd_in = 16'h0;
    #1;

    // Reset held two cycles.
    tick1(); push(4'hF, SOFF, 1'b1, 2'd0, "reset_c1");
    tick1(); push(4'hF, SOFF, 1'b1, 2'd0, "reset_c2");
    reset = 1'b0;

    // Scan walk with zero snapshot, no blanking.
    goto_digit(0, S0, 1'b1, "walk_d0");
    goto_digit(1, S0, 1'b1, "walk_d1");
    goto_digit(2, S0, 1'b1, "walk_d2");
    goto_digit(3, S0, 1'b1, "walk_d3");
    goto_digit(0, S0, 1'b1, "walk_wrap_d0");

    do_load(16'h1234);
    goto_digit(1, S3, 1'b1, "h1234_d1");
    goto_digit(2, S2, 1'b1, "h1234_d2");
    goto_digit(3, S1, 1'b1, "h1234_d3");
    goto_digit(0, S4, 1'b1, "h1234_d0");

    blank_lz = 1'b1;
    do_load(16'h0050);
    goto_digit(1, S5,   1'b1, "h0050_d1");
    goto_digit(2, SOFF, 1'b1, "h0050_d2_blank");
    goto_digit(3, SOFF, 1'b1, "h0050_d3_blank");
    goto_digit(0, S0,   1'b1, "h0050_d0");

    do_load(16'h0000);
    goto_digit(1, SOFF, 1'b1, "h0000_d1_blank");
    goto_digit(2, SOFF, 1'b1, "h0000_d2_blank");
    goto_digit(3, SOFF, 1'b1, "h0000_d3_blank");
    goto_digit(0, S0,   1'b1, "h0000_d0");

    do_load(16'h00A7);
    goto_digit(1, SDASH, 1'b1, "h00A7_d1_dash");
    goto_digit(2, SOFF,  1'b1, "h00A7_d2_blank");
    goto_digit(3, SOFF,  1'b1, "h00A7_d3_blank");
    goto_digit(0, S7,    1'b1, "h00A7_d0");

    // Sticky overflow.
    ovr = 1'b1; tick1(); ovr = 1'b0;
    goto_digit(3, SOFF, 1'b0, "ovr_d3_dp");
    goto_digit(0, S7,   1'b1, "ovr_d0_nodp");
    goto_digit(3, SOFF, 1'b0, "ovr_d3_sticky");
    ovr = 1'b1; clr_ovr = 1'b1; tick1(); ovr = 1'b0; clr_ovr = 1'b0;
    goto_digit(3, SOFF, 1'b0, "ovr_clr_setwins");
    clr_ovr = 1'b1; tick1(); clr_ovr = 1'b0;
    goto_digit(3, SOFF, 1'b1, "clr_d3_nodp");
    goto_digit(0, S7,   1'b1, "clr_d0_nodp");

    // Freeze mid-digit, with a load during the freeze.
    goto_digit(1, SDASH, 1'b1, "pre_freeze_d1");
    tick1();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        bcd_in = 16'h0090; load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick1();
      push(4'hD, SDASH, 1'b1, 2'd1, $sformatf("freeze_c%0d", k));
    end
    load = 1'b0;
    enable = 1'b1;
    tick1();
    push(4'hD, S9, 1'b1, 2'd1, "unfreeze_new_snap");

    // Reset mid-scan.
    blank_lz = 1'b0;
    goto_digit(2, S0, 1'b1, "pre_reset_d2");
    reset = 1'b1;
    tick1();
    push(4'hF, SOFF, 1'b1, 2'd0, "midscan_reset");
    reset = 1'b0;
    tick1();
    push(4'hE, S0, 1'b1, 2'd0, "post_reset_d0");

    tick1(); tick1();
    stim_done = 1;
  end

  initial begin
    wait (stim_done);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expectations never compared, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
